// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory request/grant/response bus
interface pc_fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_gnt,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_gnt,
    output im_rvalid,
    output im_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction-fetch FSM (REQ/WAIT/HOLD/DRAIN)
// Optional FETCH_ALIGN_CHECK_EN adds if_misalign and suppresses fetches of unaligned PCs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        npc,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  input  logic               stall,
  pc_fetch_unit_if.master    im,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_instr
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               if_misalign
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic        run;
  logic [31:0] pc, pc_nx;
  logic        valid_nx;
  logic [31:0] ipc_nx, instr_nx;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        mis_nx;
`endif

  // run holds im_req low until the first edge after reset is released
`ifdef FETCH_ALIGN_CHECK_EN
  assign im.im_req = run && (state == REQ) && (pc[1:0] == 2'b00);
`else
  assign im.im_req = run && (state == REQ);
`endif
  assign im.im_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= REQ;
      run      <= 1'b0;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_instr <= INSTR_NOP;
`ifdef FETCH_ALIGN_CHECK_EN
      if_misalign <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      run      <= 1'b1;
      pc       <= pc_nx;
      if_valid <= valid_nx;
      if_pc    <= ipc_nx;
      if_instr <= instr_nx;
`ifdef FETCH_ALIGN_CHECK_EN
      if_misalign <= mis_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    valid_nx = if_valid;
    ipc_nx   = if_pc;
    instr_nx = if_instr;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_nx   = if_misalign;
`endif
    unique case (state)
      REQ: begin
        // a grant coinciding with flush is dropped; the new address goes out next cycle
        if (flush) begin
          pc_nx = flush_pc;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        else if (run && (pc[1:0] != 2'b00)) begin
          state_nx = HOLD;
          valid_nx = 1'b1;
          ipc_nx   = pc;
          instr_nx = INSTR_NOP;
          mis_nx   = 1'b1;
        end
`endif
        else if (im.im_req && im.im_gnt) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_nx    = flush_pc;
          state_nx = im.im_rvalid ? REQ : DRAIN;
        end else if (im.im_rvalid) begin
          valid_nx = 1'b1;
          ipc_nx   = pc;
          instr_nx = im.im_rdata;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (flush || !stall) begin
          pc_nx    = flush ? flush_pc : npc;
          valid_nx = 1'b0;
          instr_nx = INSTR_NOP;
          state_nx = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
          mis_nx   = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (flush) begin
          pc_nx = flush_pc;
        end
        if (im.im_rvalid) begin
          state_nx = REQ;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        if_misalign;
`endif

  int checks;
  int failures;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .npc      (npc),
    .flush    (flush),
    .flush_pc (flush_pc),
    .stall    (stall),
    .im       (bus.master),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .if_misalign (if_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] npc;
    int          stall_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // zero-wait memory: grant in the request cycle, response on the next
  task automatic do_fetch(input vec_t v);
    chk("req_high", {31'd0, bus.im_req}, 32'd1);
    chk("req_addr", bus.im_addr, v.pc);
    bus.im_gnt = 1'b1;
    step();
    bus.im_gnt    = 1'b0;
    chk("wait_req_low", {31'd0, bus.im_req}, 32'd0);
    bus.im_rvalid = 1'b1;
    bus.im_rdata  = v.rdata;
    step();
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = 32'h0;
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_pc", if_pc, v.pc);
    chk("hold_instr", if_instr, v.rdata);
    npc   = v.npc;
    stall = (v.stall_cyc > 0);
    for (int i = 0; i < v.stall_cyc; i++) begin
      step();
      if (i == v.stall_cyc - 1) stall = 1'b0;
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, v.pc);
      chk("stall_instr", if_instr, v.rdata);
      chk("stall_addr", bus.im_addr, v.pc);
    end
    step();
    chk("handoff_valid", {31'd0, if_valid}, 32'd0);
    chk("handoff_instr", if_instr, 32'h0);
    chk("handoff_addr", bus.im_addr, v.npc);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    npc           = 32'h0;
    flush         = 1'b0;
    flush_pc      = 32'h0;
    stall         = 1'b0;
    bus.im_gnt    = 1'b0;
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = 32'h0;

    vecs[0] = '{pc: 32'h0000_3000, rdata: 32'h3C01_1234, npc: 32'h0000_3004, stall_cyc: 0};
    vecs[1] = '{pc: 32'h0000_3004, rdata: 32'h2002_0005, npc: 32'h0000_3008, stall_cyc: 4};
    vecs[2] = '{pc: 32'h0000_3008, rdata: 32'hAAAA_5555, npc: 32'h0000_3100, stall_cyc: 1};
    vecs[3] = '{pc: 32'h0000_3100, rdata: 32'h1234_5678, npc: 32'hFFFF_FFFC, stall_cyc: 0};
    vecs[4] = '{pc: 32'hFFFF_FFFC, rdata: 32'h8765_4321, npc: 32'h0000_3200, stall_cyc: 2};

    step();
    step();
    chk("rst_req", {31'd0, bus.im_req}, 32'd0);
    chk("rst_addr", bus.im_addr, 32'h0000_3000);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0000_3000);
    chk("rst_instr", if_instr, 32'h0);
    reset = 1'b1;
    #1;
    chk("release_req_low", {31'd0, bus.im_req}, 32'd0);
    step();

    for (int k = 0; k < 5; k++) do_fetch(vecs[k]);

    // flush in WAIT, orphaned response arrives three cycles later
    bus.im_gnt = 1'b1;
    step();
    bus.im_gnt = 1'b0;
    flush      = 1'b1;
    flush_pc   = 32'h0000_3100;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_valid", {31'd0, if_valid}, 32'd0);
      chk("drain_req", {31'd0, bus.im_req}, 32'd0);
      step();
    end
    bus.im_rvalid = 1'b1;
    bus.im_rdata  = 32'hDEAD_BEEF;
    step();
    bus.im_rvalid = 1'b0;
    chk("drain_done_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_done_instr", if_instr, 32'h0);
    chk("drain_done_req", {31'd0, bus.im_req}, 32'd1);
    chk("drain_done_addr", bus.im_addr, 32'h0000_3100);

    // flush and response in the same WAIT cycle
    bus.im_gnt = 1'b1;
    step();
    bus.im_gnt    = 1'b0;
    flush         = 1'b1;
    flush_pc      = 32'h0000_3300;
    bus.im_rvalid = 1'b1;
    bus.im_rdata  = 32'hDEAD_BEEF;
    step();
    flush         = 1'b0;
    bus.im_rvalid = 1'b0;
    chk("flush_rv_valid", {31'd0, if_valid}, 32'd0);
    chk("flush_rv_req", {31'd0, bus.im_req}, 32'd1);
    chk("flush_rv_addr", bus.im_addr, 32'h0000_3300);

    // flush in REQ alongside a grant: grant is not counted
    flush      = 1'b1;
    flush_pc   = 32'h0000_3400;
    bus.im_gnt = 1'b1;
    step();
    flush      = 1'b0;
    bus.im_gnt = 1'b0;
    chk("req_flush_req", {31'd0, bus.im_req}, 32'd1);
    chk("req_flush_addr", bus.im_addr, 32'h0000_3400);

    // flush beats stall in HOLD
    bus.im_gnt = 1'b1;
    step();
    bus.im_gnt    = 1'b0;
    bus.im_rvalid = 1'b1;
    bus.im_rdata  = 32'h0BAD_F00D;
    step();
    bus.im_rvalid = 1'b0;
    chk("hold2_instr", if_instr, 32'h0BAD_F00D);
    chk("hold2_pc", if_pc, 32'h0000_3400);
    stall    = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h0000_3500;
    step();
    stall = 1'b0;
    flush = 1'b0;
    chk("hold_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("hold_flush_addr", bus.im_addr, 32'h0000_3500);

    // reset while in WAIT with a stale response during reset
    bus.im_gnt = 1'b1;
    step();
    bus.im_gnt    = 1'b0;
    reset         = 1'b0;
    bus.im_rvalid = 1'b1;
    bus.im_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("midrst_req", {31'd0, bus.im_req}, 32'd0);
    chk("midrst_addr", bus.im_addr, 32'h0000_3000);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("postrst_req", {31'd0, bus.im_req}, 32'd1);
    chk("postrst_addr", bus.im_addr, 32'h0000_3000);
    chk("postrst_valid", {31'd0, if_valid}, 32'd0);
    bus.im_rvalid = 1'b0;
    step();
    chk("postrst_stale_valid", {31'd0, if_valid}, 32'd0);
    do_fetch('{pc: 32'h0000_3000, rdata: 32'h3C01_1234, npc: 32'h0000_3006, stall_cyc: 0});

`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_req_low", {31'd0, bus.im_req}, 32'd0);
    step();
    chk("mis_flag", {31'd0, if_misalign}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_pc", if_pc, 32'h0000_3006);
    chk("mis_instr", if_instr, 32'h0);
    chk("mis_hold_req", {31'd0, bus.im_req}, 32'd0);
    npc = 32'h0000_3010;
    step();
    chk("mis_clear", {31'd0, if_misalign}, 32'd0);
    chk("mis_next_addr", bus.im_addr, 32'h0000_3010);
    chk("mis_next_req", {31'd0, bus.im_req}, 32'd1);
`else
    chk("unaligned_req", {31'd0, bus.im_req}, 32'd1);
    chk("unaligned_addr", bus.im_addr, 32'h0000_3006);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
